// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
//   Signal   : enable/disable control level
//   RegAddr  : architectural register index
//   HzState  : controller FSM state
// Also provides the default FLUSH_CYCLES / MEM_TIMEOUT values used by hazard_ctrl.
package hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned FLUSH_CYCLES_DEF = 1;
  localparam int unsigned MEM_TIMEOUT_DEF  = 255;

  typedef logic [REG_ADDR_W-1:0] RegAddr;

  typedef enum logic {
    DISABLE = 1'b0,
    ENABLE  = 1'b1
  } Signal;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } HzState;

  function automatic Signal to_signal(input logic b);
    return b ? ENABLE : DISABLE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// hazard_cmp: purely combinational forwarding and load-use detection.
// Ports:
//   d_rs_a, d_rt_a, d_uses_rs, d_uses_rt : decode-stage source operands
//   x_rd_a, x_reg_write, x_mem_read      : X-stage destination / load flag
//   m_rd_a, m_reg_write                  : M-stage destination
//   fwdX_rs/rt, fwdM_rs/rt               : forward selects (X has priority over M)
//   load_use                             : X-stage load feeds a used decode source
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  RegAddr d_rs_a,
  input  RegAddr d_rt_a,
  input  logic   d_uses_rs,
  input  logic   d_uses_rt,
  input  RegAddr x_rd_a,
  input  Signal  x_reg_write,
  input  logic   x_mem_read,
  input  RegAddr m_rd_a,
  input  Signal  m_reg_write,
  output Signal  fwdX_rs,
  output Signal  fwdX_rt,
  output Signal  fwdM_rs,
  output Signal  fwdM_rt,
  output logic   load_use
);

  logic w_x_wr, w_m_wr;
  logic w_x_rs_hit, w_x_rt_hit, w_m_rs_hit, w_m_rt_hit;
  logic w_fx_rs, w_fx_rt;

  // Register 0 is hard-wired, so a write to it never produces a dependency.
  assign w_x_wr = (x_reg_write == ENABLE) && (x_rd_a != '0);
  assign w_m_wr = (m_reg_write == ENABLE) && (m_rd_a != '0);

  assign w_x_rs_hit = d_uses_rs && w_x_wr && (x_rd_a == d_rs_a);
  assign w_x_rt_hit = d_uses_rt && w_x_wr && (x_rd_a == d_rt_a);
  assign w_m_rs_hit = d_uses_rs && w_m_wr && (m_rd_a == d_rs_a);
  assign w_m_rt_hit = d_uses_rt && w_m_wr && (m_rd_a == d_rt_a);

  // A load's data is not available in X, so it cannot be forwarded from there.
  assign w_fx_rs = w_x_rs_hit && !x_mem_read;
  assign w_fx_rt = w_x_rt_hit && !x_mem_read;

  assign fwdX_rs  = to_signal(w_fx_rs);
  assign fwdX_rt  = to_signal(w_fx_rt);
  assign fwdM_rs  = to_signal(w_m_rs_hit && !w_fx_rs);
  assign fwdM_rt  = to_signal(w_m_rt_hit && !w_fx_rt);
  assign load_use = x_mem_read && (w_x_rs_hit || w_x_rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (forwarding, load-use stall,
// branch flush, data-memory freeze with timeout).
// Optional build macro: HAZARD_PERF_EN adds saturating performance counters.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   d_*/x_*/m_*                      : stage operand/destination info
//   x_branch_taken                   : taken branch resolved in X
//   mem_req, mem_ready               : data-memory handshake
//   fwdX_rs/rt, fwdM_rs/rt           : forward selects to the DX register
//   stall                            : ENABLE = DX advances, DISABLE = bubble
//   pc_hold, fd_hold, fd_flush       : front-end control
//   freeze                           : hold PC/FD/DX/XM/MW
//   mem_err                          : sticky memory timeout flag
//   stall_cnt, flush_cnt, freeze_cnt : perf counters (HAZARD_PERF_EN only)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  RegAddr d_rs_a,
  input  RegAddr d_rt_a,
  input  logic   d_uses_rs,
  input  logic   d_uses_rt,
  input  RegAddr x_rd_a,
  input  Signal  x_reg_write,
  input  logic   x_mem_read,
  input  RegAddr m_rd_a,
  input  Signal  m_reg_write,
  input  logic   x_branch_taken,
  input  logic   mem_req,
  input  logic   mem_ready,
  output Signal  fwdX_rs,
  output Signal  fwdX_rt,
  output Signal  fwdM_rs,
  output Signal  fwdM_rt,
  output Signal  stall,
  output logic   pc_hold,
  output logic   fd_hold,
  output logic   fd_flush,
  output logic   freeze,
  output logic   mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: parameter out of range");
  end

  HzState           r_state, w_state_d, w_act_state;
  logic [2:0]       r_flush_left, w_flush_left_d;
  logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_d, w_wait_next;
  logic             r_resume, w_resume_d;
  logic             r_mem_err, w_mem_err_d;
  logic             w_freeze_req, w_load_use;
  logic             w_freeze, w_flush, w_bubble, w_hold;
  Signal            w_fwdX_rs, w_fwdX_rt, w_fwdM_rs, w_fwdM_rt;

  hazard_cmp u_cmp (
    .d_rs_a      (d_rs_a),
    .d_rt_a      (d_rt_a),
    .d_uses_rs   (d_uses_rs),
    .d_uses_rt   (d_uses_rt),
    .x_rd_a      (x_rd_a),
    .x_reg_write (x_reg_write),
    .x_mem_read  (x_mem_read),
    .m_rd_a      (m_rd_a),
    .m_reg_write (m_reg_write),
    .fwdX_rs     (w_fwdX_rs),
    .fwdX_rt     (w_fwdX_rt),
    .fwdM_rs     (w_fwdM_rs),
    .fwdM_rt     (w_fwdM_rt),
    .load_use    (w_load_use)
  );

  assign w_freeze_req = mem_req && !mem_ready;
  assign w_wait_next  = r_wait_cnt + WaitW'(1);

  always_comb begin
    // The cycle mem_ready arrives the pipeline moves again, so it is handled
    // like the state we will resume into (this is where a held branch is taken).
    w_act_state = r_state;
    if (r_state == MEM_WAIT && mem_ready) begin
      w_act_state = r_resume ? FLUSH : RUN;
    end

    w_state_d      = w_act_state;
    w_flush_left_d = r_flush_left;
    w_wait_cnt_d   = r_wait_cnt;
    w_resume_d     = r_resume;
    w_mem_err_d    = r_mem_err;
    w_freeze       = 1'b0;
    w_flush        = 1'b0;
    w_bubble       = 1'b0;
    w_hold         = 1'b0;

    unique case (w_act_state)
      RUN: begin
        if (w_freeze_req) begin
          w_freeze     = 1'b1;
          w_state_d    = MEM_WAIT;
          w_wait_cnt_d = '0;
          w_resume_d   = 1'b0;
        end else if (x_branch_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_d      = FLUSH;
            w_flush_left_d = 3'(FLUSH_CYCLES - 1);
          end
        end else if (w_load_use) begin
          w_bubble = 1'b1;
          w_hold   = 1'b1;
        end
      end
      FLUSH: begin
        if (w_freeze_req) begin
          // Flush count is kept so the squash resumes after the freeze.
          w_freeze     = 1'b1;
          w_state_d    = MEM_WAIT;
          w_wait_cnt_d = '0;
          w_resume_d   = 1'b1;
        end else begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
          if (r_flush_left <= 3'd1) begin
            w_state_d = RUN;
          end else begin
            w_flush_left_d = r_flush_left - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        w_freeze = 1'b1;
        if (w_wait_next == WaitW'(MEM_TIMEOUT)) begin
          w_mem_err_d = 1'b1;
          w_state_d   = RUN;
          w_resume_d  = 1'b0;
        end else begin
          w_wait_cnt_d = w_wait_next;
        end
      end
      default: w_state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= RUN;
      r_flush_left <= '0;
      r_wait_cnt   <= '0;
      r_resume     <= 1'b0;
      r_mem_err    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_flush_left <= w_flush_left_d;
      r_wait_cnt   <= w_wait_cnt_d;
      r_resume     <= w_resume_d;
      r_mem_err    <= w_mem_err_d;
    end
  end

  // Outputs are forced idle while reset is held, independent of the inputs.
  assign fwdX_rs  = rst ? w_fwdX_rs : DISABLE;
  assign fwdX_rt  = rst ? w_fwdX_rt : DISABLE;
  assign fwdM_rs  = rst ? w_fwdM_rs : DISABLE;
  assign fwdM_rt  = rst ? w_fwdM_rt : DISABLE;
  assign stall    = (rst && w_bubble) ? DISABLE : ENABLE;
  assign pc_hold  = rst && w_hold;
  assign fd_hold  = rst && w_hold;
  assign fd_flush = rst && w_flush;
  assign freeze   = rst && w_freeze;
  assign mem_err  = r_mem_err;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_freeze_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (w_hold && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_freeze && r_freeze_cnt != '1) r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign freeze_cnt = r_freeze_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share all inputs:
//   A: FLUSH_CYCLES=3, MEM_TIMEOUT=255   B: FLUSH_CYCLES=1, MEM_TIMEOUT=3
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned FC_A = 3, TO_A = 255, FC_B = 1, TO_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  RegAddr d_rs_a, d_rt_a, x_rd_a, m_rd_a;
  logic   d_uses_rs, d_uses_rt, x_mem_read, x_branch_taken, mem_req, mem_ready;
  Signal  x_reg_write, m_reg_write;

  Signal fxrs_a, fxrt_a, fmrs_a, fmrt_a, stall_a;
  Signal fxrs_b, fxrt_b, fmrs_b, fmrt_b, stall_b;
  logic  pch_a, fdh_a, fdf_a, frz_a, err_a;
  logic  pch_b, fdh_b, fdf_b, frz_b, err_b;
`ifdef HAZARD_PERF_EN
  logic [15:0] sc_a, fc_a, zc_a, sc_b, fc_b, zc_b;
`endif

  hazard_ctrl #(.FLUSH_CYCLES(FC_A), .MEM_TIMEOUT(TO_A), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .d_rs_a(d_rs_a), .d_rt_a(d_rt_a), .d_uses_rs(d_uses_rs),
    .d_uses_rt(d_uses_rt), .x_rd_a(x_rd_a), .x_reg_write(x_reg_write),
    .x_mem_read(x_mem_read), .m_rd_a(m_rd_a), .m_reg_write(m_reg_write),
    .x_branch_taken(x_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .fwdX_rs(fxrs_a), .fwdX_rt(fxrt_a), .fwdM_rs(fmrs_a), .fwdM_rt(fmrt_a),
    .stall(stall_a), .pc_hold(pch_a), .fd_hold(fdh_a), .fd_flush(fdf_a),
    .freeze(frz_a), .mem_err(err_a)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc_a), .flush_cnt(fc_a), .freeze_cnt(zc_a)
`endif
  );

  hazard_ctrl #(.FLUSH_CYCLES(FC_B), .MEM_TIMEOUT(TO_B), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .d_rs_a(d_rs_a), .d_rt_a(d_rt_a), .d_uses_rs(d_uses_rs),
    .d_uses_rt(d_uses_rt), .x_rd_a(x_rd_a), .x_reg_write(x_reg_write),
    .x_mem_read(x_mem_read), .m_rd_a(m_rd_a), .m_reg_write(m_reg_write),
    .x_branch_taken(x_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .fwdX_rs(fxrs_b), .fwdX_rt(fxrt_b), .fwdM_rs(fmrs_b), .fwdM_rt(fmrt_b),
    .stall(stall_b), .pc_hold(pch_b), .fd_hold(fdh_b), .fd_flush(fdf_b),
    .freeze(frz_b), .mem_err(err_b)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc_b), .flush_cnt(fc_b), .freeze_cnt(zc_b)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: "waiting" flag, wait count, remaining squash cycles, sticky error.
  bit m_won[2], p_won[2], m_err[2], p_err[2];
  int m_wcnt[2], p_wcnt[2], m_fl[2], p_fl[2];
  int m_cs[2], p_cs[2], m_cf[2], p_cf[2], m_cz[2], p_cz[2];
  bit e_frz[2], e_fl[2], e_hold[2];

  function automatic int fcyc(input int k);
    return (k == 0) ? FC_A : FC_B;
  endfunction

  function automatic int tmo(input int k);
    return (k == 0) ? TO_A : TO_B;
  endfunction

  function automatic int sat_inc(input int v, input bit en);
    return (en && v < 65535) ? v + 1 : v;
  endfunction

  function automatic bit fx(input RegAddr src, input bit used);
    return used && x_reg_write == ENABLE && x_rd_a == src && x_rd_a != 0 && !x_mem_read;
  endfunction

  function automatic bit fm(input RegAddr src, input bit used);
    return used && m_reg_write == ENABLE && m_rd_a == src && m_rd_a != 0 && !fx(src, used);
  endfunction

  function automatic bit ld_use();
    return x_mem_read && x_reg_write == ENABLE && x_rd_a != 0 &&
           ((d_uses_rs && x_rd_a == d_rs_a) || (d_uses_rt && x_rd_a == d_rt_a));
  endfunction

  task automatic mdl_reset(input int k);
    m_won[k] = 0; m_wcnt[k] = 0; m_fl[k] = 0; m_err[k] = 0;
    m_cs[k] = 0; m_cf[k] = 0; m_cz[k] = 0;
  endtask

  task automatic mdl_eval(input int k);
    e_frz[k] = 0; e_fl[k] = 0; e_hold[k] = 0;
    p_won[k] = m_won[k]; p_wcnt[k] = m_wcnt[k]; p_fl[k] = m_fl[k]; p_err[k] = m_err[k];
    if (!rst) return;
    if (m_won[k] && !mem_ready) begin
      e_frz[k] = 1;
      if (m_wcnt[k] + 1 == tmo(k)) begin
        p_err[k] = 1; p_won[k] = 0; p_fl[k] = 0;
      end else begin
        p_wcnt[k] = m_wcnt[k] + 1;
      end
    end else begin
      p_won[k] = 0;
      if (mem_req && !mem_ready) begin
        e_frz[k] = 1; p_won[k] = 1; p_wcnt[k] = 0;
      end else if (m_fl[k] > 0) begin
        e_fl[k] = 1; p_fl[k] = m_fl[k] - 1;
      end else if (x_branch_taken) begin
        e_fl[k] = 1; p_fl[k] = fcyc(k) - 1;
      end else if (ld_use()) begin
        e_hold[k] = 1;
      end
    end
    p_cs[k] = sat_inc(m_cs[k], e_hold[k]);
    p_cf[k] = sat_inc(m_cf[k], e_fl[k]);
    p_cz[k] = sat_inc(m_cz[k], e_frz[k]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k, input Signal fxrs, input Signal fxrt,
                           input Signal fmrs, input Signal fmrt, input Signal stl,
                           input logic pch, input logic fdh, input logic fdf,
                           input logic frz, input logic err);
    string p;
    p = (k == 0) ? "A" : "B";
    chk({p, ".fwdX_rs"}, fxrs, rst && fx(d_rs_a, d_uses_rs));
    chk({p, ".fwdX_rt"}, fxrt, rst && fx(d_rt_a, d_uses_rt));
    chk({p, ".fwdM_rs"}, fmrs, rst && fm(d_rs_a, d_uses_rs));
    chk({p, ".fwdM_rt"}, fmrt, rst && fm(d_rt_a, d_uses_rt));
    chk({p, ".stall"}, stl, (e_fl[k] || e_hold[k]) ? 0 : 1);
    chk({p, ".pc_hold"}, pch, e_hold[k]);
    chk({p, ".fd_hold"}, fdh, e_hold[k]);
    chk({p, ".fd_flush"}, fdf, e_fl[k]);
    chk({p, ".freeze"}, frz, e_frz[k]);
    chk({p, ".mem_err"}, err, m_err[k]);
  endtask

  task automatic settle();
    #2;
    n_vec++;
    for (int k = 0; k < 2; k++) mdl_eval(k);
    check_dut(0, fxrs_a, fxrt_a, fmrs_a, fmrt_a, stall_a, pch_a, fdh_a, fdf_a, frz_a, err_a);
    check_dut(1, fxrs_b, fxrt_b, fmrs_b, fmrt_b, stall_b, pch_b, fdh_b, fdf_b, frz_b, err_b);
`ifdef HAZARD_PERF_EN
    chk("A.stall_cnt", sc_a, m_cs[0]); chk("A.flush_cnt", fc_a, m_cf[0]);
    chk("A.freeze_cnt", zc_a, m_cz[0]);
    chk("B.stall_cnt", sc_b, m_cs[1]); chk("B.flush_cnt", fc_b, m_cf[1]);
    chk("B.freeze_cnt", zc_b, m_cz[1]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) mdl_reset(k);
      else begin
        m_won[k] = p_won[k]; m_wcnt[k] = p_wcnt[k]; m_fl[k] = p_fl[k]; m_err[k] = p_err[k];
        m_cs[k] = p_cs[k]; m_cf[k] = p_cf[k]; m_cz[k] = p_cz[k];
      end
    end
    #1;
  endtask

  task automatic idle();
    d_rs_a = 0; d_rt_a = 0; d_uses_rs = 0; d_uses_rt = 0;
    x_rd_a = 0; x_reg_write = DISABLE; x_mem_read = 0;
    m_rd_a = 0; m_reg_write = DISABLE;
    x_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) mdl_reset(k);
    // Reset held with every hazard source active: outputs must stay idle.
    idle();
    d_rs_a = 5; d_uses_rs = 1; x_rd_a = 5; x_reg_write = ENABLE;
    x_branch_taken = 1; mem_req = 1;
    @(posedge clk); #1;
    settle();
    chk("rst.freeze", frz_a, 0); chk("rst.stall", stall_a, ENABLE);
    chk("rst.fwdX_rs", fxrs_a, DISABLE); chk("rst.fd_flush", fdf_b, 0);
    tick();
    rst = 1; idle();
    settle(); tick();

    // X has priority over M for the same source.
    d_rs_a = 5; d_uses_rs = 1; x_rd_a = 5; x_reg_write = ENABLE;
    m_rd_a = 5; m_reg_write = ENABLE;
    settle();
    chk("fwd.x_rs", fxrs_a, ENABLE); chk("fwd.m_rs", fmrs_a, DISABLE);
    tick();

    // Load-use on rt: one bubble, then the load forwards from M.
    idle();
    x_mem_read = 1; x_rd_a = 8; x_reg_write = ENABLE; d_rt_a = 8; d_uses_rt = 1;
    settle();
    chk("lu.stall", stall_a, DISABLE); chk("lu.pc_hold", pch_a, 1); chk("lu.fd_hold", fdh_a, 1);
    tick();
    x_mem_read = 0; x_rd_a = 3; m_rd_a = 8; m_reg_write = ENABLE;
    settle();
    chk("lu.fwdM_rt", fmrt_a, ENABLE); chk("lu.release", stall_a, ENABLE);
    tick();

    // Register 0 never forwards or stalls.
    idle();
    x_rd_a = 0; x_reg_write = ENABLE; x_mem_read = 1; d_rs_a = 0; d_uses_rs = 1;
    m_rd_a = 0; m_reg_write = ENABLE;
    settle();
    chk("r0.fwdX", fxrs_a, DISABLE); chk("r0.fwdM", fmrs_a, DISABLE);
    chk("r0.stall", stall_a, ENABLE);
    tick();

    // Branch together with load-use: A squashes 3 cycles, B only one.
    idle();
    x_branch_taken = 1; x_mem_read = 1; x_rd_a = 8; x_reg_write = ENABLE;
    d_rt_a = 8; d_uses_rt = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("br.fd_flush", fdf_a, 1); chk("br.pc_hold", pch_a, 0);
      tick();
      x_branch_taken = 0;
    end
    settle();
    chk("br.done", fdf_a, 0); chk("br.lu_after", pch_a, 1); chk("br.b_lu", pch_b, 1);
    tick();

    // Freeze inside FLUSH: squash count is held and resumes after the freeze.
    idle();
    x_branch_taken = 1;
    settle(); tick();
    x_branch_taken = 0; mem_req = 1;
    settle(); chk("ff.freeze", frz_a, 1); chk("ff.noflush", fdf_a, 0); tick();
    settle(); tick();
    mem_ready = 1;
    settle(); chk("ff.resume", fdf_a, 1); tick();
    mem_req = 0; mem_ready = 0;
    settle(); chk("ff.last", fdf_a, 1); tick();
    settle(); chk("ff.done", fdf_a, 0); tick();

    // Memory wait: 4 waiting cycles after the request cycle; B times out at 3.
    idle();
    mem_req = 1;
    for (int i = 0; i < 5; i++) begin
      settle(); chk("mw.freeze", frz_a, 1); tick();
    end
    mem_ready = 1;
    settle(); chk("mw.release", frz_a, 0); tick();
    idle();
    settle();
    chk("to.mem_err", err_b, 1); chk("to.run", frz_b, 0); chk("to.a_ok", err_a, 0);
    tick();

    // Reset in the middle of MEM_WAIT.
    mem_req = 1;
    settle(); tick(); settle(); tick();
    #2; rst = 0; #1;
    chk("arst.freeze_a", frz_a, 0); chk("arst.freeze_b", frz_b, 0);
    chk("arst.mem_err", err_b, 0);
`ifdef HAZARD_PERF_EN
    chk("arst.freeze_cnt", zc_a, 0); chk("arst.stall_cnt", sc_a, 0);
    chk("arst.flush_cnt", fc_a, 0);
`endif
    tick();
    rst = 1; idle();
    settle(); chk("arst.run", frz_a, 0); tick();

    // Reset in the middle of FLUSH drops the remainder.
    x_branch_taken = 1;
    settle(); tick();
    x_branch_taken = 0;
    #2; rst = 0; #1;
    chk("frst.flush", fdf_a, 0);
    tick();
    rst = 1;
    settle(); chk("frst.discard", fdf_a, 0); tick();

    // Randomized traffic over a small register range so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      d_rs_a = RegAddr'($urandom_range(0, 3));
      d_rt_a = RegAddr'($urandom_range(0, 3));
      x_rd_a = RegAddr'($urandom_range(0, 3));
      m_rd_a = RegAddr'($urandom_range(0, 3));
      d_uses_rs = 1'($urandom_range(0, 1));
      d_uses_rt = 1'($urandom_range(0, 1));
      x_reg_write = Signal'($urandom_range(0, 1));
      m_reg_write = Signal'($urandom_range(0, 1));
      x_mem_read = ($urandom_range(0, 9) < 3);
      x_branch_taken = ($urandom_range(0, 19) < 3);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 9) < 6);
      settle(); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning total squash cycles per taken branch, including the detect cycle (1..7).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum MEM_WAIT cycles before mem_err sets.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the performance counter width.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have inputs: d_rs_a, d_rt_a  in  RegAddr  decode source addresses; d_uses_rs, d_uses_rt  in  1  source is read.
REQ-006 SHALL have inputs: x_rd_a  in  RegAddr; x_reg_write  in  Signal; x_mem_read  in  1  X-stage instruction is a load.
REQ-007 SHALL have inputs: m_rd_a  in  RegAddr; m_reg_write  in  Signal  M-stage destination.
REQ-008 SHALL have inputs: x_branch_taken  in  1; mem_req  in  1; mem_ready  in  1  data-memory handshake.
REQ-009 SHALL have outputs: fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt  out  Signal  forward selects to the DX register.
REQ-010 SHALL have output stall  out  Signal, where ENABLE = DX advances and DISABLE = DX loads a bubble.
REQ-011 SHALL have outputs: pc_hold, fd_hold, fd_flush, freeze  out  1  (freeze holds PC/FD/DX/XM/MW); mem_err  out  1  sticky.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT, FLUSH, all with Mealy outputs.
REQ-013 SHALL compute forward selects combinationally in every state.
REQ-014 SHALL assert fwdX_rs when d_uses_rs && x_reg_write==ENABLE && x_rd_a==d_rs_a && x_rd_a!=0 && !x_mem_read.
REQ-015 SHALL assert fwdM_rs when d_uses_rs && m_reg_write==ENABLE && m_rd_a==d_rs_a && m_rd_a!=0 && !fwdX_rs.
REQ-016 SHALL derive fwdX_rt and fwdM_rt identically to REQ-014/REQ-015 using the rt operands.
REQ-017 SHALL flag load-use when x_mem_read && x_reg_write==ENABLE && x_rd_a!=0 && x_rd_a matches a used d source.
REQ-018 SHALL, on load-use in RUN with no higher priority event, drive stall=DISABLE, pc_hold=1, fd_hold=1 for exactly that cycle.
REQ-019 SHALL, in RUN when mem_req && !mem_ready, drive freeze=1 and go to MEM_WAIT; this event has priority 1.
REQ-020 SHALL, in MEM_WAIT, hold freeze=1 until the cycle mem_ready=1, in which freeze=0 and the next state is RUN.
REQ-021 SHALL, in RUN when x_branch_taken (priority 2), drive fd_flush=1 and stall=DISABLE, ignoring load-use.
REQ-022 SHALL, on a taken branch with FLUSH_CYCLES>1, enter FLUSH and stay for FLUSH_CYCLES-1 cycles with fd_flush=1, stall=DISABLE.
REQ-023 SHALL, when FLUSH_CYCLES==1, remain in RUN after a taken branch.
REQ-024 SHALL let a freeze request in FLUSH take priority: go to MEM_WAIT, hold the flush count, and resume FLUSH afterwards.
REQ-025 SHALL, when a branch is presented during freeze, take no action; the branch is handled after freeze drops.
REQ-026 SHALL set mem_err and return to RUN when the MEM_WAIT cycle counter reaches MEM_TIMEOUT.
REQ-027 SHALL keep mem_err set until reset.
REQ-028 SHALL drive all non-stall outputs 0/DISABLE and stall=ENABLE when no hazard is present.

Reset
REQ-029 SHALL, while rst is low, force state=RUN, counters=0, mem_err=0, and all outputs to their REQ-028 values.
REQ-030 SHALL abort MEM_WAIT or FLUSH immediately on reset mid-operation; the flush remainder is discarded.

Configuration
REQ-031 SHALL, with HAZARD_PERF_EN defined, add outputs stall_cnt, flush_cnt, freeze_cnt (CNT_W each).
REQ-032 SHALL increment those counters once per cycle of load-use stall, fd_flush, and freeze respectively.
REQ-033 SHALL saturate those counters at all-ones.
REQ-034 SHALL, without HAZARD_PERF_EN, have no such ports and no counter logic.

Structure
REQ-035 SHALL place the HzState enum and the FLUSH_CYCLES and MEM_TIMEOUT defaults in package definitions, alongside Signal and RegAddr.
REQ-036 SHALL implement forwarding/load-use compare as sub-module hazard_cmp (pure combinational), instantiated once.

Verification
REQ-037 SHALL check: d_rs_a=5, x_rd_a=5, x_reg_write=ENABLE, m_rd_a=5 -> fwdX_rs=ENABLE, fwdM_rs=DISABLE.
REQ-038 SHALL check: x_mem_read=1, x_rd_a=8, d_rt_a=8 used -> one cycle stall=DISABLE, pc_hold=fd_hold=1; next cycle, load in M -> fwdM_rt=ENABLE.
REQ-039 SHALL check: x_rd_a=0 writes with d_rs_a=0 -> no forward, no stall.
REQ-040 SHALL check: FLUSH_CYCLES=3, x_branch_taken plus a load-use in the same cycle -> fd_flush=1 for 3 cycles, pc_hold=0.
REQ-041 SHALL check: mem_req=1 with mem_ready low for 4 cycles -> freeze=1 for 5 cycles; MEM_TIMEOUT=3 instead -> mem_err=1, state RUN.
REQ-042 SHALL check: rst low asserted mid-MEM_WAIT -> freeze=0 asynchronously, mem_err=0, and the HAZARD_PERF_EN counters read 0.
